uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing the single `uart_tx` transmitter buffer between N byte-stream requesters (console echo, status reporter, debug dump). Requesters present bytes with a `last` flag. Once granted, a requester keeps the transmitter until its `last` byte is accepted, so multi-byte messages are never interleaved. The block sits between the requesters and `uart_tx` `data_in`/`write_buffer`/`buffer_full`, in the `clk` domain that also drives `en_16_x_baud`.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types, defaults and helpers for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned N_REQ_DEF        = 4;
    localparam int unsigned IDLE_TIMEOUT_DEF = 1024;
    localparam int unsigned IDX_W            = 3;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width of the idle counter; IDLE_TIMEOUT >= 2 keeps this at least 1.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles);
    endfunction

    // Successor of idx modulo n.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input int unsigned n);
        return ((32'(idx) + 32'd1) >= n) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning rr, rr+1, ... mod N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Rotate so that bit k of rot corresponds to requester (rr + k) mod N.
    always_comb begin
        dbl   = {req, req};
        rot   = N'(dbl >> rr);
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                idx   = ((32'(rr) + k) >= N) ? IDX_W'(32'(rr) + k - N)
                                             : IDX_W'(32'(rr) + k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter feeding a single uart_tx buffer.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = N_REQ_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           tx_data,
    output logic                 tx_write,
    input  logic                 tx_full,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner,
    output logic                 timeout
);

    localparam int unsigned      CNT_W   = cnt_width(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT - 1);

    arb_state_t       state, state_nx;
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [CNT_W-1:0] idle_cnt;
    logic             own_req;
    logic             own_last;
    logic [7:0]       own_data;
    logic             accept;
    logic             expire;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req),
        .rr    (rr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Select the current owner's request lane.
    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                own_req  = req[i];
                own_last = req_last[i];
                own_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_valid) state_nx = LOCK;
            LOCK:    if ((accept && own_last) || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accept is gated by tx_write because buffer_full lags a write by one cycle.
    always_comb begin
        accept = 1'b0;
        expire = 1'b0;
        if (state == LOCK) begin
            accept = own_req && !tx_full && !tx_write;
            expire = !own_req && (idle_cnt == CNT_MAX);
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ack[i] = accept && (owner == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_write <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            timeout  <= 1'b0;
            rr       <= '0;
            idle_cnt <= '0;
        end else begin
            tx_write <= accept;
            timeout  <= expire;
            busy     <= (state_nx == LOCK);
            if (accept) begin
                tx_data <= own_data;
            end
            if (state == IDLE && pick_valid) begin
                owner <= pick_idx;
            end
            if (state == LOCK && !own_req && !expire) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end else begin
                idle_cnt <= '0;
            end
            if ((accept && own_last) || expire) begin
                rr <= rr_next(owner, N_REQ);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int          NR  = 4;
    localparam int unsigned TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [31:0]  req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] ack;
    logic [7:0]   tx_data;
    logic         tx_write;
    logic         tx_full;
    logic         busy;
    logic [2:0]   owner;
    logic         timeout;

    uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_write (tx_write),
        .tx_full  (tx_full),
        .busy     (busy),
        .owner    (owner),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_ack;
        logic        e_wr;
        logic [7:0]  e_dat;
        logic        e_busy;
        logic [2:0]  e_own;
        logic        e_to;
    } vec_t;

    vec_t vecs [11];

    // Requester model: per-requester message memory, head advances on ack.
    logic [8:0]  mem [NR][32];
    int          head [NR];
    int          tail [NR];
    logic [7:0]  wlog [$];
    int          to_cyc [$];
    int          cyc;
    int          ack_cnt;
    logic [3:0]  last_a;
    logic        last_busy;
    logic        prev_w;
    logic        fifo_mode;
    int          fifo_cnt;
    int          fcyc;
    int          full_seen;

    task automatic push(input int r, input logic [7:0] b, input logic l);
        mem[r][tail[r]] = {l, b};
        tail[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (head[r] < tail[r]) begin
                req[r]              = 1'b1;
                req_data[8*r +: 8]  = mem[r][head[r]][7:0];
                req_last[r]         = mem[r][head[r]][8];
            end else begin
                req[r]              = 1'b0;
                req_data[8*r +: 8]  = 8'h00;
                req_last[r]         = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [3:0] a;
        logic       w;
        logic [7:0] d;
        @(negedge clk);
        a         = ack;
        w         = tx_write;
        d         = tx_data;
        last_a    = a;
        last_busy = busy;
        if (timeout) to_cyc.push_back(cyc);
        if (a != 4'b0) begin
            ack_cnt++;
            ntests++;
            if (!$onehot(a) || ((a & req) != a)) begin
                nfail++;
                $display("FAIL ack_legal: ack=%b req=%b", a, req);
            end
        end
        if (w) begin
            ntests++;
            if (prev_w) begin
                nfail++;
                $display("FAIL write_gap: back-to-back tx_write at cycle %0d", cyc);
            end
            if (fifo_mode) begin
                ntests++;
                if (fifo_cnt >= 16) begin
                    nfail++;
                    $display("FAIL overflow: write with fifo count %0d", fifo_cnt);
                end
            end
            wlog.push_back(d);
        end
        prev_w = w;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) if (a[r]) head[r]++;
        if (fifo_mode) begin
            fcyc++;
            if (w) fifo_cnt++;
            if (fcyc >= 60 && (fcyc % 4) == 0 && fifo_cnt > 0) fifo_cnt--;
            tx_full = (fifo_cnt >= 16);
            if (tx_full) full_seen++;
        end
        drive();
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wlog.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({name, " bytes"}, 32'(wlog.size()), 32'(n));
    endtask

    function automatic logic [7:0] wl(input int i);
        return (wlog.size() > i) ? wlog[i] : 8'h00;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        tx_full   = 1'b0;
        fifo_mode = 1'b0;
        prev_w    = 1'b0;
        for (int r = 0; r < NR; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
        wlog.delete();
        to_cyc.delete();
        drive();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc     = 0;
        ack_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_ack;
        int k;
        int w0;
        int t0;
        int a0;

        vecs[0]  = '{4'b0010, 32'h0000_4800, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{4'b0010, 32'h0000_4800, 4'b0000, 1'b0, 4'b0010, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
        vecs[2]  = '{4'b0010, 32'h0000_6900, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h48, 1'b1, 3'd1, 1'b0};
        vecs[3]  = '{4'b0010, 32'h0000_6900, 4'b0010, 1'b0, 4'b0010, 1'b0, 8'h48, 1'b1, 3'd1, 1'b0};
        vecs[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h69, 1'b0, 3'd1, 1'b0};
        vecs[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h69, 1'b0, 3'd1, 1'b0};
        vecs[6]  = '{4'b1011, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h69, 1'b0, 3'd1, 1'b0};
        vecs[7]  = '{4'b1011, 32'h3300_0000, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'h69, 1'b1, 3'd3, 1'b0};
        vecs[8]  = '{4'b0011, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 1'b0, 3'd3, 1'b0};
        vecs[9]  = '{4'b0011, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 1'b1, 3'd0, 1'b0};
        vecs[10] = '{4'b0011, 32'h0000_000F, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'h33, 1'b1, 3'd0, 1'b0};

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        tx_full  = 1'b0;
        @(posedge clk);
        #1;
        chk("reset ack",     32'(ack),      32'h0);
        chk("reset tx_write", 32'(tx_write), 32'h0);
        chk("reset tx_data", 32'(tx_data),  32'h0);
        chk("reset busy",    32'(busy),     32'h0);
        chk("reset owner",   32'(owner),    32'h0);
        chk("reset timeout", 32'(timeout),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single message from requester 1, then rr=2 decides a three-way contest.
        for (int i = 0; i < 11; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            req_last = vecs[i].last;
            tx_full  = vecs[i].full;
            @(negedge clk);
            chk($sformatf("row%0d ack", i),      32'(ack),      32'(vecs[i].e_ack));
            chk($sformatf("row%0d tx_write", i), 32'(tx_write), 32'(vecs[i].e_wr));
            chk($sformatf("row%0d tx_data", i),  32'(tx_data),  32'(vecs[i].e_dat));
            chk($sformatf("row%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
            chk($sformatf("row%0d owner", i),    32'(owner),    32'(vecs[i].e_own));
            chk($sformatf("row%0d timeout", i),  32'(timeout),  32'(vecs[i].e_to));
            @(posedge clk);
            #1;
        end

        // Contention: two 3-byte messages, never interleaved, then wrap from rr=3.
        do_reset();
        push(0, 8'h0a, 1'b0); push(0, 8'h0b, 1'b0); push(0, 8'h0c, 1'b1);
        push(2, 8'h2a, 1'b0); push(2, 8'h2b, 1'b0); push(2, 8'h2c, 1'b1);
        drive();
        run_until(6, 100, "contention");
        chk("cont b0", 32'(wl(0)), 32'h0a);
        chk("cont b1", 32'(wl(1)), 32'h0b);
        chk("cont b2", 32'(wl(2)), 32'h0c);
        chk("cont b3", 32'(wl(3)), 32'h2a);
        chk("cont b4", 32'(wl(4)), 32'h2b);
        chk("cont b5", 32'(wl(5)), 32'h2c);
        push(0, 8'h0d, 1'b1);
        push(2, 8'h2d, 1'b1);
        drive();
        run_until(8, 50, "rewrap");
        chk("rewrap first", 32'(wl(6)), 32'h0d);
        chk("rewrap second", 32'(wl(7)), 32'h2d);

        // Backpressure: 20 cycles of tx_full inside a lock.
        do_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        drive();
        run_until(1, 20, "bp first");
        tx_full = 1'b1;
        w0 = wlog.size();
        t0 = to_cyc.size();
        a0 = ack_cnt;
        repeat (20) step();
        chk("bp acks", 32'(ack_cnt - a0), 32'h0);
        chk("bp writes", 32'(wlog.size() - w0), 32'h0);
        chk("bp timeouts", 32'(to_cyc.size() - t0), 32'h0);
        chk("bp busy", 32'(last_busy), 32'h1);
        tx_full = 1'b0;
        run_until(3, 20, "bp resume");
        chk("bp b1", 32'(wl(1)), 32'h12);
        chk("bp b2", 32'(wl(2)), 32'h13);

        // Timeout: owner 3 stalls after one non-last byte.
        do_reset();
        push(3, 8'h31, 1'b0);
        drive();
        t_ack = -1;
        k = 0;
        while (t_ack < 0 && k < 10) begin
            step();
            if (last_a[3]) t_ack = cyc - 1;
            k++;
        end
        chk("tmo ack seen", 32'(t_ack >= 0), 32'h1);
        push(0, 8'h01, 1'b1);
        push(1, 8'h02, 1'b1);
        drive();
        k = 0;
        while (to_cyc.size() == 0 && k < 40) begin
            step();
            k++;
        end
        chk("tmo pulse seen", 32'(to_cyc.size()), 32'h1);
        chk("tmo delay", 32'((to_cyc.size() > 0) ? (to_cyc[0] - t_ack) : -1), 32'd17);
        chk("tmo busy", 32'(last_busy), 32'h0);
        run_until(3, 30, "tmo after");
        chk("tmo kept byte", 32'(wl(0)), 32'h31);
        chk("tmo next r0", 32'(wl(1)), 32'h01);
        chk("tmo then r1", 32'(wl(2)), 32'h02);
        chk("tmo single pulse", 32'(to_cyc.size()), 32'h1);

        // Reset in the middle of a 4-byte message with rr advanced to 2.
        do_reset();
        push(1, 8'h51, 1'b1);
        drive();
        run_until(1, 20, "pre msg");
        push(2, 8'ha1, 1'b0); push(2, 8'ha2, 1'b0); push(2, 8'ha3, 1'b0); push(2, 8'ha4, 1'b1);
        drive();
        run_until(3, 30, "mid msg");
        chk("mid busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async ack",      32'(ack),      32'h0);
        chk("async tx_write", 32'(tx_write), 32'h0);
        chk("async tx_data",  32'(tx_data),  32'h0);
        chk("async busy",     32'(busy),     32'h0);
        chk("async owner",    32'(owner),    32'h0);
        chk("async timeout",  32'(timeout),  32'h0);
        do_reset();
        push(2, 8'ha1, 1'b1);
        push(0, 8'h05, 1'b1);
        drive();
        run_until(2, 30, "post reset");
        chk("post reset r0 first", 32'(wl(0)), 32'h05);
        chk("post reset r2 next", 32'(wl(1)), 32'ha1);

        // Streaming 20 bytes into a 16-deep FIFO with registered full.
        do_reset();
        fifo_mode = 1'b1;
        fifo_cnt  = 0;
        fcyc      = 0;
        full_seen = 0;
        for (int i = 0; i < 20; i++) push(2, 8'(8'h80 + i), (i == 19));
        drive();
        run_until(20, 400, "stream");
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stream b%0d", i), 32'(wl(i)), 32'(8'h80 + i));
        end
        chk("stream full reached", 32'(full_seen > 0), 32'h1);
        chk("stream no timeout", 32'(to_cyc.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
